mem_arbiter: RTL and testbench

Shared-memory arbiter between the I-cache and D-cache fill ports and the single pipelined main memory. It accepts line-fill requests from either cache and single-word write-through stores from the D-cache, and grants the memory to one transaction at a time. For fills it generates the 8-word burst itself and routes the returned words to the requesting cache's `memory_data_valid` input. The non-granted cache sees `memory_busy`.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/response and main-memory signals seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if;
  logic        i_fill_req;
  logic [15:0] i_addr;
  logic        d_fill_req;
  logic        d_wr_req;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        i_mem_busy;
  logic        i_mem_valid;
  logic        d_mem_busy;
  logic        d_mem_valid;
  logic        d_wr_done;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  modport slave (
    input  i_fill_req, i_addr, d_fill_req, d_wr_req, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_mem_busy, i_mem_valid, d_mem_busy, d_mem_valid, d_wr_done, rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_fill_req, i_addr, d_fill_req, d_wr_req, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_mem_busy, i_mem_valid, d_mem_busy, d_mem_valid, d_wr_done, rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto one pipelined
// memory; fills are issued as 8-word bursts and returned words are routed to the owner.
module mem_arbiter #(
  parameter int unsigned MemLatency = 4,
  parameter int unsigned LineWords  = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

  state_e      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;
  logic        last_d_q, last_d_d;
  logic [15:0] st_addr_q, st_addr_d;
  logic [15:0] st_data_q, st_data_d;

  logic in_fill;
  logic d_pend;
  logic grant_i;
  logic word_valid;

  assign in_fill    = (state_q == StIFill) || (state_q == StDFill);
  assign word_valid = in_fill && bus_io.mem_valid;
  assign d_pend     = bus_io.d_wr_req | bus_io.d_fill_req;
  // Round-robin: I wins a tie only if D had the previous grant.
  assign grant_i    = bus_io.i_fill_req & (~d_pend | last_d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      last_d_q    <= 1'b0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      last_d_q    <= last_d_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    last_d_d    = last_d_q;
    st_addr_d   = st_addr_q;
    st_data_d   = st_data_q;

    bus_io.mem_en      = 1'b0;
    bus_io.mem_wr      = 1'b0;
    bus_io.mem_addr    = '0;
    bus_io.mem_wdata   = '0;
    bus_io.i_mem_busy  = 1'b0;
    bus_io.d_mem_busy  = 1'b0;
    bus_io.i_mem_valid = 1'b0;
    bus_io.d_mem_valid = 1'b0;
    bus_io.d_wr_done   = 1'b0;
    bus_io.rdata       = bus_io.mem_rdata;

    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d  = StIFill;
          base_d   = bus_io.i_addr[15:4];
          last_d_d = 1'b0;
        end else if (d_pend) begin
          last_d_d = 1'b1;
          if (bus_io.d_wr_req) begin
            state_d   = StDWrite;
            st_addr_d = bus_io.d_addr;
            st_data_d = bus_io.d_wdata;
          end else begin
            state_d = StDFill;
            base_d  = bus_io.d_addr[15:4];
          end
        end
      end
      StIFill, StDFill: begin
        if (issue_cnt_q < 4'(LineWords)) begin
          bus_io.mem_en   = 1'b1;
          bus_io.mem_addr = {base_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d     = issue_cnt_q + 4'd1;
        end
        if (word_valid) begin
          recv_cnt_d = recv_cnt_q + 4'd1;
          if (recv_cnt_q == 4'(LineWords - 1)) begin
            state_d     = StIdle;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
          end
        end
        if (state_q == StIFill) begin
          bus_io.d_mem_busy  = 1'b1;
          bus_io.i_mem_valid = word_valid;
        end else begin
          bus_io.i_mem_busy  = 1'b1;
          bus_io.d_mem_valid = word_valid;
        end
      end
      StDWrite: begin
        bus_io.mem_en     = 1'b1;
        bus_io.mem_wr     = 1'b1;
        bus_io.mem_addr   = st_addr_q;
        bus_io.mem_wdata  = st_data_q;
        bus_io.d_wr_done  = 1'b1;
        bus_io.i_mem_busy = 1'b1;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The first word of a burst can never beat the memory's fixed read latency.
  first_word_latency_a: assert property (@(posedge clk) disable iff (rst)
    (in_fill && bus_io.mem_valid && (recv_cnt_q == 4'd0)) |-> (issue_cnt_q >= 4'(MemLatency)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus a latency-4
// pipelined memory, directed scenarios with literal checks, then randomized traffic.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MemLatency(4),
    .LineWords (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  // Stimulus held by the "caches"; copied onto the bus at the start of each cycle.
  logic        rst_v = 1'b1;
  logic        i_req = 1'b0, d_fill = 1'b0, d_wr = 1'b0;
  logic [15:0] i_a = '0, d_a = '0, d_wd = '0;
  bit          inject = 1'b0;
  int          i_cnt = 0, d_cnt = 0;

  // Memory: sparse store over a hashed background, fixed 4-cycle read pipeline.
  logic [15:0] mem_store [logic [15:0]];
  logic        pipe_v [8];
  logic [15:0] pipe_d [8];

  // Reference model: 0 idle, 1 I fill, 2 D fill, 3 store.
  int          m_own = 0, m_age = 0, m_rx = 0;
  logic [11:0] m_base = '0;
  logic [15:0] m_sa = '0, m_sd = '0;
  bit          m_last_d = 1'b0;

  string glog = "";
  logic  prev_en = 1'b0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    bit          fill, issuing, st;
    logic [15:0] line, e_addr;
    fill    = (m_own == 1) || (m_own == 2);
    st      = (m_own == 3);
    issuing = fill && (m_age < 8);
    line    = {m_base, 4'h0};
    e_addr  = issuing ? line + 16'(2 * m_age) : (st ? m_sa : 16'h0);
    chk("mem_en", bus.mem_en, issuing || st);
    chk("mem_wr", bus.mem_wr, st);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, st ? m_sd : 16'h0);
    chk("d_wr_done", bus.d_wr_done, st);
    chk("i_mem_busy", bus.i_mem_busy, (m_own == 2) || st);
    chk("d_mem_busy", bus.d_mem_busy, m_own == 1);
    chk("i_mem_valid", bus.i_mem_valid, (m_own == 1) && bus.mem_valid);
    chk("d_mem_valid", bus.d_mem_valid, (m_own == 2) && bus.mem_valid);
    chk("rdata_pass", bus.rdata, bus.mem_rdata);
    if (fill && bus.mem_valid) chk("fill_word", bus.rdata, mem_rd(line + 16'(2 * m_rx)));
  endtask

  task automatic model_advance();
    bit dp;
    if (bus_rst()) begin
      m_own    = 0;
      m_last_d = 1'b0;
      m_age    = 0;
      m_rx     = 0;
      return;
    end
    case (m_own)
      0: begin
        dp    = bus.d_wr_req || bus.d_fill_req;
        m_age = 0;
        m_rx  = 0;
        if (bus.i_fill_req && (!dp || m_last_d)) begin
          m_own = 1; m_base = bus.i_addr[15:4]; m_last_d = 1'b0;
        end else if (dp) begin
          m_last_d = 1'b1;
          if (bus.d_wr_req) begin
            m_own = 3; m_sa = bus.d_addr; m_sd = bus.d_wdata;
          end else begin
            m_own = 2; m_base = bus.d_addr[15:4];
          end
        end
      end
      1, 2: begin
        m_age++;
        if (bus.mem_valid) m_rx++;
        if (m_rx == 8) m_own = 0;
      end
      default: m_own = 0;
    endcase
  endtask

  function automatic bit bus_rst();
    return rst == 1'b1;
  endfunction

  // One clock cycle: drive inputs, check outputs, update memory/caches/model.
  task automatic step();
    int slot;
    @(negedge clk);
    rst            = rst_v;
    bus.i_fill_req = i_req;
    bus.i_addr     = i_a;
    bus.d_fill_req = d_fill;
    bus.d_wr_req   = d_wr;
    bus.d_addr     = d_a;
    bus.d_wdata    = d_wd;
    slot           = cyc % 8;
    bus.mem_valid  = pipe_v[slot] | (inject && (m_own == 0 || m_own == 3));
    bus.mem_rdata  = pipe_v[slot] ? pipe_d[slot] : 16'($urandom);
    pipe_v[slot]   = 1'b0;
    #1;
    if (check_en) compare();
    if (bus.mem_en && !bus.mem_wr) begin
      pipe_v[(cyc + 4) % 8] = 1'b1;
      pipe_d[(cyc + 4) % 8] = mem_rd(bus.mem_addr);
    end
    if (bus.mem_en && bus.mem_wr) mem_store[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_en && !prev_en) glog = {glog, bus.mem_wr ? "W" : (bus.d_mem_busy ? "I" : "D")};
    prev_en = bus.mem_en;
    model_advance();
    if (bus.i_mem_valid) i_cnt++;
    if (i_cnt == 8) begin i_req = 1'b0; i_cnt = 0; end
    if (bus.d_mem_valid) d_cnt++;
    if (d_cnt == 8) begin d_fill = 1'b0; d_cnt = 0; end
    if (bus.d_wr_done) d_wr = 1'b0;
    cyc++;
  endtask

  initial begin
    int n_i, n_d, guard;
    for (int i = 0; i < 8; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end

    // Reset state
    step(); step();
    check_en = 1'b1;
    step();
    chk("reset_outputs", {bus.mem_en, bus.mem_wr, bus.i_mem_busy, bus.d_mem_busy,
        bus.i_mem_valid, bus.d_mem_valid, bus.d_wr_done}, 0);
    chk("reset_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
    rst_v = 1'b0;
    step();

    // Simultaneous fills after reset: D first, then I
    d_fill = 1'b1; d_a = 16'h2004; i_req = 1'b1; i_a = 16'h3008;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("dfirst_i_busy", bus.i_mem_busy, 1);
      chk("dfirst_d_valid", bus.d_mem_valid, k >= 5);
    end
    step();
    chk("dfirst_idle", {bus.mem_en, bus.i_mem_busy, bus.d_mem_busy}, 0);
    step();
    chk("ithen_addr", bus.mem_addr, 16'h3000);
    chk("ithen_d_busy", bus.d_mem_busy, 1);
    for (int k = 0; k < 12; k++) step();

    // I fill alone at 0x1236
    i_req = 1'b1; i_a = 16'h1236;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 8) chk("ifill_addr", bus.mem_addr, 16'h1230 + 16'(2 * (k - 1)));
      chk("ifill_d_busy", bus.d_mem_busy, 1);
      chk("ifill_i_valid", bus.i_mem_valid, k >= 5);
    end
    step();
    chk("ifill_idle_t13", {bus.mem_en, bus.d_mem_busy, bus.i_mem_busy}, 0);

    // Store has precedence over a pending D fill
    d_wr = 1'b1; d_fill = 1'b1; d_a = 16'h4000; d_wd = 16'hBEEF;
    step();
    step();
    chk("store_wr", {bus.mem_en, bus.mem_wr, bus.d_wr_done}, 3'b111);
    chk("store_addr", bus.mem_addr, 16'h4000);
    chk("store_wdata", bus.mem_wdata, 16'hBEEF);
    step();
    chk("store_done_once", bus.d_wr_done, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 5) chk("store_readback", {15'h0, bus.d_mem_valid, bus.rdata}, {16'h1, 16'hBEEF});
    end
    step();

    // Back-to-back alternating contention, three per side
    glog = ""; n_i = 0; n_d = 0; guard = 0;
    while (!(n_i == 3 && n_d == 3 && !i_req && !d_fill) && guard < 200) begin
      if (!i_req && n_i < 3) begin i_req = 1'b1; i_a = 16'($urandom); n_i++; end
      if (!d_fill && n_d < 3) begin d_fill = 1'b1; d_a = 16'($urandom); n_d++; end
      step();
      guard++;
    end
    chk("alt_timeout", guard < 200, 1);
    chk("alt_order", (glog == "IDIDID"), 1);

    // Reset at burst issue 5 aborts the fill
    i_req = 1'b1; i_a = 16'h5550;
    step();
    for (int k = 0; k < 4; k++) step();
    rst_v = 1'b1;
    step();
    chk("rst_issue5_addr", bus.mem_addr, 16'h5558);
    rst_v = 1'b0; i_req = 1'b0; i_cnt = 0;
    step();
    chk("rst_outputs_zero", {bus.mem_en, bus.d_mem_busy, bus.i_mem_busy, bus.mem_addr}, 0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_late_valid", {bus.i_mem_valid, bus.d_mem_valid}, 0);
      step();
    end
    i_req = 1'b1; i_a = 16'h6660;
    for (int k = 0; k < 14; k++) step();
    chk("rst_refill_done", i_req, 0);

    // Spurious mem_valid in IDLE and D_WRITE
    inject = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("inj_idle", {bus.mem_valid, bus.i_mem_valid, bus.d_mem_valid}, 3'b100);
    end
    d_wr = 1'b1; d_a = 16'h7002; d_wd = 16'h1234;
    step();
    step();
    chk("inj_dwrite", {bus.mem_valid, bus.mem_wr, bus.d_mem_valid, bus.i_mem_valid}, 4'b1100);
    inject = 1'b0; d_fill = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 6) chk("inj_fill_word1", bus.rdata, 16'h1234);
    end
    step();
    chk("inj_fill_done", {d_fill, bus.mem_en, bus.i_mem_busy}, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (!i_req && $urandom_range(0, 3) == 0) begin i_req = 1'b1; i_a = 16'($urandom); end
      if (!d_fill && !d_wr && $urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, 2);
        d_a = 16'($urandom); d_wd = 16'($urandom);
        d_wr = (r != 1); d_fill = (r != 0);
      end
      inject = ($urandom_range(0, 3) == 0);
      step();
    end
    inject = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
